sha256_arbiter: RTL

Round-robin arbiter and sequencer that shares one `sha256` core among `NUM_REQ` requesters. Each requester streams a fixed 640-bit message as 64 ten-bit beats. The arbiter grants one requester at a time, drives the core's start/load handshake, and forwards the 26 ten-bit digest beats tagged with the requester ID. After each job it recycles the core through a local reset so the core is idle for the next job.

---
 rtl/sha256_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sha256_arbiter.sv
// Round-robin sharing of one sha256 core: grant, start, load 64 beats, drain 26 digest beats, recycle the core.
// Latency: req_valid in IDLE -> core_start next cycle -> first req_ready the cycle after; rsp_* lag core_valid_out by 1.
// Backpressure: message load stalls on gaps in req_valid[gnt]; the response path has none (consumer takes every beat).
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_data/req_ready   per-requester 10-bit message beat handshake (requester i on bits i*10 +: 10)
//   rsp_valid/rsp_data/rsp_id/rsp_last  digest beats tagged with the owning requester, last on beat 26
//   err_timeout                    one-cycle pulse when the digest watchdog expires
//   busy                           high whenever a job is in flight (state != IDLE)
//   core_*                         start/load/digest interface and local reset of the shared core
module sha256_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int MSG_BEATS  = 64,
   parameter int HASH_BEATS = 26,
   parameter int TIMEOUT    = 2048,
   parameter int IDW        = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*10-1:0]   req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    rsp_valid,
   output logic [9:0]              rsp_data,
   output logic [IDW-1:0]          rsp_id,
   output logic                    rsp_last,
   output logic                    err_timeout,
   output logic                    busy,
   output logic                    core_start,
   output logic                    core_valid_in,
   output logic [9:0]              core_message_in,
   input  logic [9:0]              core_hash_out,
   input  logic                    core_valid_out,
   output logic                    core_rst_n
);

   localparam int BCW = $clog2(MSG_BEATS + 1);
   localparam int OCW = $clog2(HASH_BEATS + 1);
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [IDW:0] NREQ_W = (IDW+1)'(NUM_REQ);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_LOAD, ST_DRAIN, ST_RECYCLE} state_t;

   state_t          r_state;
   logic [IDW-1:0]  r_gnt_id;
   logic [IDW-1:0]  r_rr_ptr;
   logic [BCW-1:0]  r_beat_cnt;
   logic [OCW-1:0]  r_out_cnt;
   logic [WDW-1:0]  r_wd_cnt;
   logic            r_rcy_cnt;
   logic            r_core_start;
   logic            r_rsp_valid;
   logic [9:0]      r_rsp_data;
   logic [IDW-1:0]  r_rsp_id;
   logic            r_rsp_last;
   logic            r_err_timeout;

   logic            w_any;
   logic [IDW-1:0]  w_pick;
   logic [IDW:0]    w_sum;
   logic            w_load;
   logic            w_gnt_vld;
   logic [9:0]      w_gnt_dat;
   logic            w_accept;

   // Scan downward from the farthest offset so the final overwrite is the
   // first requesting index at or above rr_ptr (with wrap).
   always_comb begin
      w_any  = 1'b0;
      w_pick = r_rr_ptr;
      w_sum  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
         if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
         if (req_valid[w_sum[IDW-1:0]]) begin
            w_any  = 1'b1;
            w_pick = w_sum[IDW-1:0];
         end
      end
   end

   // Granted requester's beat, selected with constant slice offsets.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_dat = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_gnt_id == IDW'(i)) begin
            w_gnt_vld = req_valid[i];
            w_gnt_dat = req_data[i*10 +: 10];
         end
      end
   end

   assign w_load = (r_state == ST_LOAD);

   always_comb begin
      req_ready           = '0;
      req_ready[r_gnt_id] = w_load;
   end

   assign core_valid_in   = w_load & w_gnt_vld;
   assign core_message_in = w_load ? w_gnt_dat : 10'd0;
   assign w_accept        = core_valid_in;

   // Core is held in reset with the arbiter and during the 2-cycle recycle.
   assign core_rst_n  = rst_n & (r_state != ST_RECYCLE);
   assign busy        = (r_state != ST_IDLE);
   assign core_start  = r_core_start;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign rsp_id      = r_rsp_id;
   assign rsp_last    = r_rsp_last;
   assign err_timeout = r_err_timeout;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_gnt_id      <= '0;
         r_rr_ptr      <= '0;
         r_beat_cnt    <= '0;
         r_out_cnt     <= '0;
         r_wd_cnt      <= '0;
         r_rcy_cnt     <= 1'b0;
         r_core_start  <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_id      <= '0;
         r_rsp_last    <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_core_start  <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_last    <= 1'b0;
         r_err_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_gnt_id     <= w_pick;
                  r_core_start <= 1'b1;
                  r_state      <= ST_START;
               end
            end
            ST_START: begin
               r_beat_cnt <= '0;
               r_state    <= ST_LOAD;
            end
            ST_LOAD: begin
               if (w_accept && (r_beat_cnt < BCW'(MSG_BEATS))) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
                  if (r_beat_cnt == BCW'(MSG_BEATS - 1)) begin
                     r_out_cnt <= '0;
                     r_wd_cnt  <= '0;
                     r_state   <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (core_valid_out) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= core_hash_out;
                  r_rsp_id    <= r_gnt_id;
                  r_wd_cnt    <= '0;
                  if (r_out_cnt < OCW'(HASH_BEATS)) r_out_cnt <= r_out_cnt + 1'b1;
                  if (r_out_cnt == OCW'(HASH_BEATS - 1)) begin
                     r_rsp_last <= 1'b1;
                     r_rcy_cnt  <= 1'b0;
                     r_state    <= ST_RECYCLE;
                  end
               end else if (r_wd_cnt == WDW'(TIMEOUT - 1)) begin
                  // TIMEOUT consecutive cycles without a digest beat
                  r_err_timeout <= 1'b1;
                  r_rcy_cnt     <= 1'b0;
                  r_state       <= ST_RECYCLE;
               end else begin
                  r_wd_cnt <= r_wd_cnt + 1'b1;
               end
            end
            ST_RECYCLE: begin
               if (r_rcy_cnt) begin
                  r_rr_ptr <= (r_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
                  r_state  <= ST_IDLE;
               end else begin
                  r_rcy_cnt <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
